reg_file_ctrl: RTL and testbench

//  Initiator side of the 8x8 reg_file port set (READREG1/2, WRITEREG, WRITEDATA,

---
 rtl/reg_file_ctrl_pkg.sv | 52 +++++
 rtl/reg_file_ctrl_alu.sv | 27 ++
 rtl/reg_file_ctrl.sv | 130 +++++++++++++
 tb/tb_reg_file_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_ctrl_pkg
//   Shared definitions for the reg_file initiator: opcode values, instruction
//   field positions, ALU select codes and controller FSM states.
//   No ports; imported by reg_file_ctrl and reg_file_ctrl_alu.
package reg_file_ctrl_pkg;

    // Opcodes (INSTR[31:24])
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    // Instruction field LSB positions
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned DEST_LSB = 16;
    localparam int unsigned SRC1_LSB = 8;
    localparam int unsigned SRC2_LSB = 0;

    typedef enum logic [2:0] {
        ALU_FWD,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_ERR
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op <= OP_OR);
    endfunction

    // mov forwards operand b (src2); loadi never goes through the ALU
    function automatic alu_sel_t op_to_alu(input logic [7:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_FWD;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_ctrl_alu.sv
// reg_file_ctrl_alu
//   Combinational W-bit ALU: forward b, a+b, a-b, a&b, a|b; all mod 2^W.
//   Ports: a, b (operands), sel (alu_sel_t), y (result).
module reg_file_ctrl_alu
    import reg_file_ctrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_sel_t     sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            ALU_FWD: y = b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
//   Initiator for an 8x8 reg_file: accepts one 32-bit instruction over
//   valid/ready, reads two operands, computes a result and issues one write.
//   Ports:
//     CLK, RESET (async, active-low)
//     INSTR[31:0], INSTR_VALID in; INSTR_READY out
//     READREG1/2 out, REGOUT1/2 in   - reg_file read side
//     WRITEREG, WRITEDATA, WRITEENABLE out - reg_file write side
//     DONE (pulse with write), ERROR (pulse on unknown opcode)
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTR,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    output logic [ADDR_W-1:0] READREG1,
    output logic [ADDR_W-1:0] READREG2,
    input  logic [DATA_W-1:0] REGOUT1,
    input  logic [DATA_W-1:0] REGOUT2,
    output logic [ADDR_W-1:0] WRITEREG,
    output logic [DATA_W-1:0] WRITEDATA,
    output logic              WRITEENABLE,
    output logic              DONE,
    output logic              ERROR
);

    state_t            state_q, state_d;
    logic              live_q;      // low until the first edge after reset release
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] dest_q, src1_q, src2_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
    logic [DATA_W-1:0] alu_y;
    logic [7:0]        op_in;
    logic              accept;

    // Upper bits of the register index fields are don't-care
    logic unused_fields;
    assign unused_fields = ^{INSTR[23:16+ADDR_W], INSTR[15:8+ADDR_W]};

    assign op_in  = INSTR[OPC_LSB +: 8];
    assign accept = INSTR_READY & INSTR_VALID;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        INSTR_READY = 1'b0;
        WRITEENABLE = 1'b0;
        DONE        = 1'b0;
        ERROR       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                INSTR_READY = live_q;
                if (INSTR_VALID && live_q) begin
                    if (op_in == OP_LOADI)  state_d = ST_WRITE;
                    else if (!op_known(op_in)) state_d = ST_ERR;
                    else                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                WRITEENABLE = 1'b1;
                DONE        = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                ERROR   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are captured on the READ->EXEC edge (reg_file data has settled
    // during READ), the ALU evaluates them during EXEC and the result register
    // loads on the EXEC->WRITE edge, so a write to dest never feeds its own source.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_q     <= '0;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            if (state_q == ST_IDLE && accept) begin
                op_q   <= op_in;
                dest_q <= INSTR[DEST_LSB +: ADDR_W];
                src1_q <= INSTR[SRC1_LSB +: ADDR_W];
                src2_q <= INSTR[SRC2_LSB +: ADDR_W];
                if (op_in == OP_LOADI)
                    result_q <= INSTR[SRC2_LSB +: DATA_W];
            end
            if (state_q == ST_READ) begin
                op_a_q <= REGOUT1;
                op_b_q <= REGOUT2;
            end
            if (state_q == ST_EXEC)
                result_q <= alu_y;
        end
    end

    reg_file_ctrl_alu #(.W(DATA_W)) u_alu (
        .a   (op_a_q),
        .b   (op_b_q),
        .sel (op_to_alu(op_q)),
        .y   (alu_y)
    );

    assign READREG1  = src1_q;
    assign READREG2  = src2_q;
    assign WRITEREG  = dest_q;
    assign WRITEDATA = result_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
//   Bench for reg_file_ctrl with a behavioural 8x8 reg_file attached.
//   Directed instruction sequence, reset cases, then randomized instructions
//   checked against an instruction-level reference register array.
module tb_reg_file_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] INSTR = '0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [2:0]  READREG1, READREG2, WRITEREG;
    logic [7:0]  REGOUT1, REGOUT2, WRITEDATA;
    logic        WRITEENABLE, DONE, ERROR;

    always #5 CLK = ~CLK;

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .WRITEREG    (WRITEREG),
        .WRITEDATA   (WRITEDATA),
        .WRITEENABLE (WRITEENABLE),
        .DONE        (DONE),
        .ERROR       (ERROR)
    );

    // Behavioural reg_file: async read, write on posedge
    logic [7:0] rf [0:7] = '{default: 8'h00};
    always @(posedge CLK) if (WRITEENABLE) rf[WRITEREG] <= WRITEDATA;
    assign REGOUT1 = rf[READREG1];
    assign REGOUT2 = rf[READREG2];

    // Reference architectural register state
    logic [7:0] ref_rf [0:7];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Instruction semantics; -1 marks an unknown opcode
    function automatic int ref_result(input logic [7:0] op, input int a, input int b, input int imm);
        case (op)
            8'h00:   return imm;
            8'h01:   return b;
            8'h02:   return (a + b) % 256;
            8'h03:   return (a - b + 256) % 256;
            8'h04:   return a & b;
            8'h05:   return a | b;
            default: return -1;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int t = 0;
        while (INSTR_READY !== 1'b1 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check({tag, "_ready"}, 32'(INSTR_READY), 32'd1);
    endtask

    // Issue one instruction from a negedge and follow it to completion
    task automatic run_instr(input string tag, input logic [7:0] op, input logic [7:0] d,
                             input logic [7:0] s1, input logic [7:0] s2);
        int exp;
        int lat;
        wait_ready(tag);
        exp = ref_result(op, int'(ref_rf[s1[2:0]]), int'(ref_rf[s2[2:0]]), int'(s2));
        INSTR       = {op, d, s1, s2};
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        // junk while busy must be ignored
        INSTR       = $urandom;
        INSTR_VALID = 1'($urandom_range(0, 1));
        if (exp < 0) begin
            @(negedge CLK);
            INSTR_VALID = 1'b0;
            check({tag, "_err"}, {29'd0, ERROR, WRITEENABLE, INSTR_READY}, 32'b100);
            @(negedge CLK);
            check({tag, "_err_after"}, {29'd0, ERROR, WRITEENABLE, INSTR_READY}, 32'b001);
        end else begin
            lat = (op == 8'h00) ? 1 : 3;
            for (int i = 0; i < lat; i++) begin
                @(negedge CLK);
                if (i == lat - 1) begin
                    INSTR_VALID = 1'b0;
                    check({tag, "_we"}, {28'd0, WRITEENABLE, DONE, ERROR, INSTR_READY}, 32'b1100);
                    check({tag, "_wdata"}, {21'd0, WRITEREG, WRITEDATA}, {21'd0, d[2:0], 8'(exp)});
                end else begin
                    check({tag, "_busy"}, {28'd0, WRITEENABLE, DONE, ERROR, INSTR_READY}, 32'b0000);
                end
            end
            ref_rf[d[2:0]] = 8'(exp);
            @(negedge CLK);
            check({tag, "_rf"}, 32'(rf[d[2:0]]), 32'(exp));
            check({tag, "_idle"}, {30'd0, WRITEENABLE, INSTR_READY}, 32'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;

        // Reset state
        #3;
        check("rst_outs", {INSTR_READY, WRITEENABLE, DONE, ERROR, READREG1, READREG2, WRITEREG, WRITEDATA},
              32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rst_release_ready_low", 32'(INSTR_READY), 32'd0);
        @(negedge CLK);
        check("rst_first_edge_ready", 32'(INSTR_READY), 32'd1);

        // Directed sequence
        run_instr("loadi_r1", 8'h00, 8'd1, 8'd0, 8'd28);
        check("r1_is_28", 32'(rf[1]), 32'd28);
        run_instr("loadi_r2", 8'h00, 8'd2, 8'd0, 8'd200);
        run_instr("loadi_r3", 8'h00, 8'd3, 8'd0, 8'd100);
        run_instr("add_r4",   8'h02, 8'd4, 8'd2, 8'd3);
        check("add_wrap_44", 32'(rf[4]), 32'd44);
        run_instr("sub_r5",   8'h03, 8'd5, 8'd3, 8'd2);
        check("sub_9c", 32'(rf[5]), 32'h9C);
        run_instr("and_r6",   8'h04, 8'd6, 8'd2, 8'd3);
        check("and_40", 32'(rf[6]), 32'h40);
        run_instr("or_r7",    8'h05, 8'd7, 8'd2, 8'd3);
        check("or_ec", 32'(rf[7]), 32'hEC);
        run_instr("add_r1_self", 8'h02, 8'd1, 8'd1, 8'd1);
        check("r1_is_56", 32'(rf[1]), 32'd56);
        run_instr("mov_r0",   8'h01, 8'd0, 8'd5, 8'd7);
        run_instr("bad_07",   8'h07, 8'd2, 8'd1, 8'd1);
        run_instr("bad_ff",   8'hFF, 8'd3, 8'd1, 8'd1);
        check("bad_no_write_r2", 32'(rf[2]), 32'd200);

        // Reset pulled low in EXEC with VALID held high back-to-back
        wait_ready("rst_exec");
        INSTR       = {8'h02, 8'd4, 8'd1, 8'd2};
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("rst_exec_busy", {30'd0, INSTR_READY, WRITEENABLE}, 32'd0);
        RESET = 1'b0;
        #1;
        check("rst_exec_outs", {INSTR_READY, WRITEENABLE, DONE, ERROR, READREG1, READREG2, WRITEREG, WRITEDATA},
              32'd0);
        repeat (2) @(negedge CLK);
        check("rst_exec_no_write", 32'(rf[4]), 32'(ref_rf[4]));
        INSTR_VALID = 1'b0;
        RESET = 1'b1;
        run_instr("loadi_after_rst", 8'h00, 8'd4, 8'd0, 8'h5A);

        // Reset pulled low during WRITE
        wait_ready("rst_write");
        INSTR       = {8'h00, 8'd5, 8'd0, 8'h33};
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        INSTR_VALID = 1'b0;
        check("rst_write_we_high", 32'(WRITEENABLE), 32'd1);
        #1;
        RESET = 1'b0;
        #1;
        check("rst_write_we_drop", {29'd0, WRITEENABLE, DONE, INSTR_READY}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("rst_write_no_write", 32'(rf[5]), 32'(ref_rf[5]));
        RESET = 1'b1;

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(6, 255));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_instr("rand", op, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 8; i++) check("final_rf", 32'(rf[i]), 32'(ref_rf[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
